// File: rtl/countdown_timer_core.sv
// MM:SS BCD countdown timer clocked by clk_50MHz; the slow clock is synchronised and used only as a tick enable.
// Optional TIMER_ALARM_BLINK_EN: alarm toggles on each slow tick while expired instead of holding steady.
module countdown_timer_core #(
  parameter int TICKS_PER_SEC = 2
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        clk_2MHz,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0] SUB_MAX = 8'(TICKS_PER_SEC - 1);

  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [7:0]  sub_q, sub_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        alarm_q, alarm_d;
  logic [1:0]  tick_sync_q, start_sync_q, clear_sync_q;
  logic        tick_prev_q, start_prev_q, clear_prev_q;
  logic        tick_pulse, start_pulse, clear_pulse;
  logic [15:0] dec_value;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

  // BCD borrow chain across all four digits.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick_pulse  = tick_sync_q[1]  & ~tick_prev_q;
  assign start_pulse = start_sync_q[1] & ~start_prev_q;
  assign clear_pulse = clear_sync_q[1] & ~clear_prev_q;
  assign dec_value   = bcd_dec(digits_q);

  // Next-state, digit and output decode; priority is clear > start > second strobe.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    sub_d    = sub_q;
    done_d   = 1'b0;
    if (clear_pulse) begin
      state_d  = S_IDLE;
      digits_d = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pulse) begin
            if (digits_q != 16'd0) begin
              state_d = S_RUN;
              sub_d   = 8'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (load) begin
            digits_d = {clamp_digit(load_value[15:12], 4'd9), clamp_digit(load_value[11:8], 4'd9),
                        clamp_digit(load_value[7:4], 4'd5), clamp_digit(load_value[3:0], 4'd9)};
          end else begin
            digits_d = digits_q;
          end
        end
        S_RUN: begin
          if (start_pulse) begin
            state_d = S_PAUSE;
          end else if (tick_pulse) begin
            if (sub_q >= SUB_MAX) begin
              sub_d    = 8'd0;
              digits_d = dec_value;
              if (dec_value == 16'd0) begin
                state_d = S_EXPIRED;
                done_d  = 1'b1;
              end else begin
                state_d = S_RUN;
              end
            end else begin
              sub_d = sub_q + 8'd1;
            end
          end else begin
            sub_d = sub_q;
          end
        end
        S_PAUSE: begin
          if (start_pulse) begin
            state_d = S_RUN;
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_EXPIRED: begin
          if (start_pulse) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_EXPIRED;
          end
        end
        default: begin
          state_d  = S_IDLE;
          digits_d = 16'd0;
        end
      endcase
    end
    running_d = (state_d == S_RUN);
`ifdef TIMER_ALARM_BLINK_EN
    if (state_d == S_EXPIRED) begin
      if (state_q != S_EXPIRED) begin
        alarm_d = 1'b1;
      end else if (tick_pulse) begin
        alarm_d = ~alarm_q;
      end else begin
        alarm_d = alarm_q;
      end
    end else begin
      alarm_d = 1'b0;
    end
`else
    alarm_d = (state_d == S_EXPIRED);
`endif
  end

  // Synchronisers, edge detectors, state and registered outputs.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync_q  <= 2'b00;
      start_sync_q <= 2'b00;
      clear_sync_q <= 2'b00;
      tick_prev_q  <= 1'b0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
      state_q      <= S_IDLE;
      digits_q     <= 16'd0;
      sub_q        <= 8'd0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      tick_sync_q  <= {tick_sync_q[0], clk_2MHz};
      start_sync_q <= {start_sync_q[0], start_stop};
      clear_sync_q <= {clear_sync_q[0], clear};
      tick_prev_q  <= tick_sync_q[1];
      start_prev_q <= start_sync_q[1];
      clear_prev_q <= clear_sync_q[1];
      state_q      <= state_d;
      digits_q     <= digits_d;
      sub_q        <= sub_d;
      running_q    <= running_d;
      done_q       <= done_d;
      alarm_q      <= alarm_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = digits_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed plus randomized bench for countdown_timer_core against a seconds-based reference model.
module tb_countdown_timer_core;

  localparam int TPS = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slow_clk;
  logic        start_stop, clear, load;
  logic [15:0] load_value;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        running, done, alarm;

  int total = 0;
  int bad = 0;
  int obs_done = 0;
  int m_secs = 0, m_state = M_IDLE, m_sub = 0, m_alarm = 0, m_done = 0;

  countdown_timer_core #(.TICKS_PER_SEC(TPS)) dut (
    .clk_50MHz(clk), .rst_n(rst_n), .clk_2MHz(slow_clk), .start_stop(start_stop),
    .clear(clear), .load(load), .load_value(load_value), .min_tens(min_tens),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done), .alarm(alarm)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) obs_done++;
  end

  // ---------------- reference model (time kept as plain seconds) ----------------
  task automatic m_tick();
    if (m_state == M_EXP) begin
`ifdef TIMER_ALARM_BLINK_EN
      m_alarm = 1 - m_alarm;
`endif
    end else if (m_state == M_RUN) begin
      if (m_sub == TPS - 1) begin
        m_sub = 0;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_state = M_EXP;
          m_alarm = 1;
          m_done++;
        end
      end else begin
        m_sub++;
      end
    end
  endtask

  task automatic m_start();
    case (m_state)
      M_IDLE:  if (m_secs != 0) begin m_state = M_RUN; m_sub = 0; end
      M_RUN:   m_state = M_PAUSE;
      M_PAUSE: m_state = M_RUN;
      default: begin m_state = M_IDLE; m_alarm = 0; end
    endcase
  endtask

  task automatic m_clear();
    m_state = M_IDLE;
    m_secs  = 0;
    m_alarm = 0;
  endtask

  task automatic m_load(input int v);
    int mt, mo, st, so;
    mt = (v / 4096) % 16; mo = (v / 256) % 16; st = (v / 16) % 16; so = v % 16;
    if (mt > 9) mt = 9;
    if (mo > 9) mo = 9;
    if (st > 5) st = 5;
    if (so > 9) so = 9;
    if (m_state == M_IDLE) m_secs = (mt * 10 + mo) * 60 + st * 10 + so;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slow_edges(input int n);
    for (int i = 0; i < n; i++) begin
      slow_clk = 1'b1; m_tick(); cycles(10);
      slow_clk = 1'b0; cycles(10);
    end
  endtask

  task automatic press_start();
    start_stop = 1'b1; m_start(); cycles(6);
    start_stop = 1'b0; cycles(6);
  endtask

  task automatic press_clear();
    clear = 1'b1; m_clear(); cycles(6);
    clear = 1'b0; cycles(6);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v; m_load(int'(v)); cycles(1);
    load = 1'b0; cycles(2);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int mm, ss;
    mm = m_secs / 60; ss = m_secs % 60;
    check({tag, ".min_tens"}, 32'(min_tens), mm / 10);
    check({tag, ".min_ones"}, 32'(min_ones), mm % 10);
    check({tag, ".sec_tens"}, 32'(sec_tens), ss / 10);
    check({tag, ".sec_ones"}, 32'(sec_ones), ss % 10);
    check({tag, ".running"}, 32'(running), (m_state == M_RUN) ? 1 : 0);
    check({tag, ".alarm"}, 32'(alarm), m_alarm);
    check({tag, ".done_count"}, obs_done, m_done);
  endtask

  initial begin
    logic [15:0] rv;
    rst_n = 1'b0; slow_clk = 1'b0; start_stop = 1'b0; clear = 1'b0;
    load = 1'b0; load_value = 16'd0;
    cycles(3);
    check_all("reset");
    check("reset.done", 32'(done), 0);
    rst_n = 1'b1;
    cycles(2);

    // 1: load and expire
    do_load(16'h0003);
    check_all("t1.load");
    press_start();
    check_all("t1.started");
    slow_edges(2); check_all("t1.0002");
    slow_edges(2); check_all("t1.0001");
    slow_edges(2); check_all("t1.expired");
    check("t1.done_once", obs_done, 1);
    press_start(); check_all("t1.back_idle");

    // 2: borrow chain
    do_load(16'h1000);
    press_start();
    slow_edges(2); check_all("t2.0959");
    check("t2.bcd", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0959);
    press_clear(); check_all("t2.clear");

    // 3: clamp
    do_load(16'h9A7F);
    check_all("t3.clamp");
    check("t3.bcd", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h9959);
    press_clear();

    // 4: pause preserves sub-second count
    do_load(16'h0005);
    press_start();
    slow_edges(3); check_all("t4.0004");
    press_start();
    slow_edges(10); check_all("t4.paused");
    press_start();
    slow_edges(1); check_all("t4.resumed_0003");
    press_clear();

    // 5: start on zero, then clear and start together in RUN
    press_start(); check_all("t5.zero_start");
    do_load(16'h0009);
    press_start();
    slow_edges(2); check_all("t5.running");
    start_stop = 1'b1; clear = 1'b1; m_clear(); cycles(6);
    start_stop = 1'b0; clear = 1'b0; cycles(6);
    check_all("t5.clear_and_start");

    // 6: asynchronous reset mid-run
    do_load(16'h0010);
    press_start();
    slow_edges(6); check_all("t6.0007");
    #3 rst_n = 1'b0;
    #1;
    m_state = M_IDLE; m_secs = 0; m_sub = 0; m_alarm = 0;
    check_all("t6.async_reset");
    check("t6.done_low", 32'(done), 0);
    cycles(2);
    rst_n = 1'b1;
    slow_edges(4); check_all("t6.after_reset");

    // randomized sessions
    for (int it = 0; it < 8; it++) begin
      press_clear();
      rv = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      do_load(rv);
      check_all("rnd.load");
      press_start();
      slow_edges($urandom_range(0, 30)); check_all("rnd.run1");
      press_start();
      slow_edges($urandom_range(0, 4)); check_all("rnd.mid");
      press_start();
      slow_edges($urandom_range(0, 40)); check_all("rnd.run2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
